// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds ops until both operands arrive (dispatch bypass + CDB wakeup), issues lowest ready index.
// Latency: one cycle from accept (or wakeup) to exValid; ex* registers hold while exReady is low, and issueReady drops only when all slots are full.
module alu_reservation_station #(
   parameter int ENTRIES = 4,
   parameter int TAG_W   = 4,
   parameter int DATA_W  = 16,
   parameter int OP_W    = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       issueValid,
   output logic                       issueReady,
   input  logic [OP_W-1:0]            issueOp,
   input  logic [TAG_W-1:0]           issueDestTag,
   input  logic                       issueSrc1Rdy,
   input  logic                       issueSrc2Rdy,
   input  logic [TAG_W-1:0]           issueSrc1Tag,
   input  logic [TAG_W-1:0]           issueSrc2Tag,
   input  logic [DATA_W-1:0]          issueSrc1Data,
   input  logic [DATA_W-1:0]          issueSrc2Data,
   input  logic                       cdbValid,
   input  logic [TAG_W-1:0]           cdbTag,
   input  logic [DATA_W-1:0]          cdbData,
   output logic                       exValid,
   input  logic                       exReady,
   output logic [OP_W-1:0]            exOp,
   output logic [TAG_W-1:0]           exDestTag,
   output logic [DATA_W-1:0]          exSrc1,
   output logic [DATA_W-1:0]          exSrc2,
   output logic [$clog2(ENTRIES):0]   occupancy
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int OCC_W = IDX_W + 1;
   localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(ENTRIES);

   logic [ENTRIES-1:0] ent_vld;
   logic [ENTRIES-1:0] src1_rdy;
   logic [ENTRIES-1:0] src2_rdy;
   logic [OP_W-1:0]    ent_op   [ENTRIES];
   logic [TAG_W-1:0]   ent_dest [ENTRIES];
   logic [TAG_W-1:0]   src1_tag [ENTRIES];
   logic [TAG_W-1:0]   src2_tag [ENTRIES];
   logic [DATA_W-1:0]  src1_dat [ENTRIES];
   logic [DATA_W-1:0]  src2_dat [ENTRIES];

   logic [ENTRIES-1:0] eligible;
   logic [IDX_W-1:0]   alloc_idx;
   logic [IDX_W-1:0]   sel_idx;
   logic               sel_any;
   logic               alloc;
   logic               load;
   logic               take;
   logic               in1_rdy;
   logic               in2_rdy;
   logic [DATA_W-1:0]  in1_dat;
   logic [DATA_W-1:0]  in2_dat;

   assign issueReady = (occupancy < FULL_CNT);
   assign alloc      = issueValid && issueReady;
   assign eligible   = ent_vld & src1_rdy & src2_rdy;
   assign load       = !exValid || exReady;
   assign take       = load && sel_any;

   // An operand broadcast in the dispatch cycle would otherwise be missed forever.
   assign in1_rdy = issueSrc1Rdy || (cdbValid && (issueSrc1Tag == cdbTag));
   assign in2_rdy = issueSrc2Rdy || (cdbValid && (issueSrc2Tag == cdbTag));
   assign in1_dat = issueSrc1Rdy ? issueSrc1Data : cdbData;
   assign in2_dat = issueSrc2Rdy ? issueSrc2Data : cdbData;

   // Descending scans so the lowest index wins.
   always_comb begin
      alloc_idx = '0;
      sel_idx   = '0;
      sel_any   = 1'b0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!ent_vld[i]) begin
            alloc_idx = IDX_W'(i);
         end
         if (eligible[i]) begin
            sel_idx = IDX_W'(i);
            sel_any = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            ent_vld[i]  <= 1'b0;
            src1_rdy[i] <= 1'b0;
            src2_rdy[i] <= 1'b0;
            ent_op[i]   <= '0;
            ent_dest[i] <= '0;
            src1_tag[i] <= '0;
            src2_tag[i] <= '0;
            src1_dat[i] <= '0;
            src2_dat[i] <= '0;
         end
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (alloc && (alloc_idx == IDX_W'(i))) begin
               ent_vld[i]  <= 1'b1;
               ent_op[i]   <= issueOp;
               ent_dest[i] <= issueDestTag;
               src1_rdy[i] <= in1_rdy;
               src2_rdy[i] <= in2_rdy;
               src1_tag[i] <= issueSrc1Tag;
               src2_tag[i] <= issueSrc2Tag;
               src1_dat[i] <= in1_dat;
               src2_dat[i] <= in2_dat;
            end else begin
               if (ent_vld[i] && !src1_rdy[i] && cdbValid && (src1_tag[i] == cdbTag)) begin
                  src1_rdy[i] <= 1'b1;
                  src1_dat[i] <= cdbData;
               end
               if (ent_vld[i] && !src2_rdy[i] && cdbValid && (src2_tag[i] == cdbTag)) begin
                  src2_rdy[i] <= 1'b1;
                  src2_dat[i] <= cdbData;
               end
               if (take && (sel_idx == IDX_W'(i))) begin
                  ent_vld[i] <= 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         exValid   <= 1'b0;
         exOp      <= '0;
         exDestTag <= '0;
         exSrc1    <= '0;
         exSrc2    <= '0;
         occupancy <= '0;
      end else begin
         if (load) begin
            exValid <= sel_any;
            if (sel_any) begin
               exOp      <= ent_op[sel_idx];
               exDestTag <= ent_dest[sel_idx];
               exSrc1    <= src1_dat[sel_idx];
               exSrc2    <= src2_dat[sel_idx];
            end
         end
         occupancy <= occupancy + OCC_W'(alloc) - OCC_W'(take);
      end
   end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed vector bench for alu_reservation_station: one record per clock, outputs checked 1 time unit after the edge.
module tb_alu_reservation_station;

   localparam int ENTRIES = 4;
   localparam int TAG_W   = 4;
   localparam int DATA_W  = 16;
   localparam int OP_W    = 4;
   localparam int OCC_W   = 3;

   typedef struct {
      logic              rst;
      logic              iv;
      logic [OP_W-1:0]   op;
      logic [TAG_W-1:0]  dest;
      logic              r1;
      logic [TAG_W-1:0]  t1;
      logic [DATA_W-1:0] d1;
      logic              r2;
      logic [TAG_W-1:0]  t2;
      logic [DATA_W-1:0] d2;
      logic              cv;
      logic [TAG_W-1:0]  ct;
      logic [DATA_W-1:0] cd;
      logic              exr;
   } in_t;

   typedef struct {
      logic              ev;
      logic              chk_pay;
      logic [OP_W-1:0]   op;
      logic [TAG_W-1:0]  dest;
      logic [DATA_W-1:0] s1;
      logic [DATA_W-1:0] s2;
      logic [OCC_W-1:0]  occ;
      logic              irdy;
   } exp_t;

   typedef struct {
      in_t  i;
      exp_t e;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              issueValid;
   logic              issueReady;
   logic [OP_W-1:0]   issueOp;
   logic [TAG_W-1:0]  issueDestTag;
   logic              issueSrc1Rdy;
   logic              issueSrc2Rdy;
   logic [TAG_W-1:0]  issueSrc1Tag;
   logic [TAG_W-1:0]  issueSrc2Tag;
   logic [DATA_W-1:0] issueSrc1Data;
   logic [DATA_W-1:0] issueSrc2Data;
   logic              cdbValid;
   logic [TAG_W-1:0]  cdbTag;
   logic [DATA_W-1:0] cdbData;
   logic              exValid;
   logic              exReady;
   logic [OP_W-1:0]   exOp;
   logic [TAG_W-1:0]  exDestTag;
   logic [DATA_W-1:0] exSrc1;
   logic [DATA_W-1:0] exSrc2;
   logic [OCC_W-1:0]  occupancy;

   int total = 0;
   int bad   = 0;
   int step  = 0;

   always #5 clk = ~clk;

   alu_reservation_station #(
      .ENTRIES(ENTRIES), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W)
   ) dut (
      .clk(clk), .rst(rst),
      .issueValid(issueValid), .issueReady(issueReady),
      .issueOp(issueOp), .issueDestTag(issueDestTag),
      .issueSrc1Rdy(issueSrc1Rdy), .issueSrc2Rdy(issueSrc2Rdy),
      .issueSrc1Tag(issueSrc1Tag), .issueSrc2Tag(issueSrc2Tag),
      .issueSrc1Data(issueSrc1Data), .issueSrc2Data(issueSrc2Data),
      .cdbValid(cdbValid), .cdbTag(cdbTag), .cdbData(cdbData),
      .exValid(exValid), .exReady(exReady),
      .exOp(exOp), .exDestTag(exDestTag),
      .exSrc1(exSrc1), .exSrc2(exSrc2),
      .occupancy(occupancy)
   );

   function automatic in_t ins(input logic r, input logic iv, input int op, input int dest,
                               input logic r1, input int t1, input int d1,
                               input logic r2, input int t2, input int d2,
                               input logic cv, input int ct, input int cd, input logic exr);
      in_t x;
      x.rst = r;   x.iv = iv;  x.op = OP_W'(op);  x.dest = TAG_W'(dest);
      x.r1 = r1;   x.t1 = TAG_W'(t1);  x.d1 = DATA_W'(d1);
      x.r2 = r2;   x.t2 = TAG_W'(t2);  x.d2 = DATA_W'(d2);
      x.cv = cv;   x.ct = TAG_W'(ct);  x.cd = DATA_W'(cd);
      x.exr = exr;
      return x;
   endfunction

   function automatic in_t idle(input logic exr);
      return ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, exr);
   endfunction

   function automatic exp_t ex(input logic ev, input logic cp, input int op, input int dest,
                               input int s1, input int s2, input int occ, input logic irdy);
      exp_t y;
      y.ev = ev;  y.chk_pay = cp;  y.op = OP_W'(op);  y.dest = TAG_W'(dest);
      y.s1 = DATA_W'(s1);  y.s2 = DATA_W'(s2);  y.occ = OCC_W'(occ);  y.irdy = irdy;
      return y;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL step %0d %s: got %0h expected %0h", step, name, act, req);
      end
   endtask

   task automatic apply(input vec_t v);
      rst           = v.i.rst;
      issueValid    = v.i.iv;
      issueOp       = v.i.op;
      issueDestTag  = v.i.dest;
      issueSrc1Rdy  = v.i.r1;
      issueSrc1Tag  = v.i.t1;
      issueSrc1Data = v.i.d1;
      issueSrc2Rdy  = v.i.r2;
      issueSrc2Tag  = v.i.t2;
      issueSrc2Data = v.i.d2;
      cdbValid      = v.i.cv;
      cdbTag        = v.i.ct;
      cdbData       = v.i.cd;
      exReady       = v.i.exr;
      @(posedge clk);
      #1;
      chk("exValid", int'(exValid), int'(v.e.ev));
      chk("occupancy", int'(occupancy), int'(v.e.occ));
      chk("issueReady", int'(issueReady), int'(v.e.irdy));
      if (v.e.chk_pay) begin
         chk("exOp", int'(exOp), int'(v.e.op));
         chk("exDestTag", int'(exDestTag), int'(v.e.dest));
         chk("exSrc1", int'(exSrc1), int'(v.e.s1));
         chk("exSrc2", int'(exSrc2), int'(v.e.s2));
      end
      step++;
   endtask

   task automatic run(input in_t i, input exp_t e);
      vec_t v;
      v.i = i;
      v.e = e;
      apply(v);
   endtask

   vec_t vecs[14];

   initial begin
      // reset
      vecs[0]  = '{ins(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), ex(0, 1, 0, 0, 0, 0, 0, 1)};
      // both operands ready: one-cycle latency to ALU
      vecs[1]  = '{ins(0, 1, 3, 5, 1, 0, 10, 1, 0, 20, 0, 0, 0, 1), ex(0, 0, 0, 0, 0, 0, 1, 1)};
      vecs[2]  = '{idle(1),                                         ex(1, 1, 3, 5, 10, 20, 0, 1)};
      vecs[3]  = '{idle(1),                                         ex(0, 0, 0, 0, 0, 0, 0, 1)};
      // src1 pending on tag 7, non-matching broadcast, then tag 7 wakes it
      vecs[4]  = '{ins(0, 1, 1, 6, 0, 7, 0, 1, 0, 3, 0, 0, 0, 1),   ex(0, 0, 0, 0, 0, 0, 1, 1)};
      vecs[5]  = '{ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 'hEE, 1), ex(0, 0, 0, 0, 0, 0, 1, 1)};
      vecs[6]  = '{idle(1),                                         ex(0, 0, 0, 0, 0, 0, 1, 1)};
      vecs[7]  = '{ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 'hAB, 1), ex(0, 0, 0, 0, 0, 0, 1, 1)};
      vecs[8]  = '{idle(1),                                         ex(1, 1, 1, 6, 'hAB, 3, 0, 1)};
      vecs[9]  = '{idle(1),                                         ex(0, 0, 0, 0, 0, 0, 0, 1)};
      // dispatch bypass: tag 2 broadcast in the accept cycle
      vecs[10] = '{ins(0, 1, 2, 8, 0, 2, 0, 1, 0, 'h11, 1, 2, 'h55, 1), ex(0, 0, 0, 0, 0, 0, 1, 1)};
      vecs[11] = '{idle(1),                                         ex(1, 1, 2, 8, 'h55, 'h11, 0, 1)};
      vecs[12] = '{idle(1),                                         ex(0, 0, 0, 0, 0, 0, 0, 1)};
      // bypass on src2 only
      vecs[13] = '{ins(0, 1, 9, 4, 1, 0, 'h21, 0, 5, 0, 1, 5, 'h77, 1), ex(0, 0, 0, 0, 0, 0, 1, 1)};

      for (int k = 0; k < 14; k++) apply(vecs[k]);
      run(idle(1), ex(1, 1, 9, 4, 'h21, 'h77, 0, 1));
      run(idle(1), ex(0, 0, 0, 0, 0, 0, 0, 1));

      // fill all slots pending on tag 9, exReady low
      for (int k = 0; k < ENTRIES; k++)
         run(ins(0, 1, 1, 10 + k, 0, 9, 0, 1, 0, k, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, k + 1, (k + 1) < ENTRIES));
      // full: an offered instruction must be ignored
      run(ins(0, 1, 1, 15, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 4, 0));
      run(ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 'h99, 0), ex(0, 0, 0, 0, 0, 0, 4, 0));
      run(idle(0), ex(1, 1, 1, 10, 'h99, 0, 3, 1));
      for (int k = 1; k < ENTRIES; k++)
         run(idle(1), ex(1, 1, 1, 10 + k, 'h99, k, 3 - k, 1));
      run(idle(1), ex(0, 0, 0, 0, 0, 0, 0, 1));

      // stall with exValid high, then accept and dispatch in the same cycle
      run(ins(0, 1, 4, 1, 1, 0, 'h100, 1, 0, 'h200, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 1, 1));
      run(ins(0, 1, 5, 2, 1, 0, 'h300, 1, 0, 'h400, 0, 0, 0, 0), ex(1, 1, 4, 1, 'h100, 'h200, 1, 1));
      for (int k = 0; k < 3; k++)
         run(idle(0), ex(1, 1, 4, 1, 'h100, 'h200, 1, 1));
      run(ins(0, 1, 6, 3, 1, 0, 'h500, 1, 0, 'h600, 0, 0, 0, 1), ex(1, 1, 5, 2, 'h300, 'h400, 1, 1));
      run(idle(1), ex(1, 1, 6, 3, 'h500, 'h600, 0, 1));
      run(idle(1), ex(0, 0, 0, 0, 0, 0, 0, 1));

      // reset mid-operation: 3 valid entries and exValid high
      run(ins(0, 1, 7, 4, 1, 0, 'h1, 1, 0, 'h2, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 1, 1));
      run(ins(0, 1, 7, 5, 0, 12, 0, 1, 0, 'h3, 0, 0, 0, 0), ex(1, 1, 7, 4, 1, 2, 1, 1));
      run(ins(0, 1, 7, 6, 0, 12, 0, 1, 0, 'h4, 0, 0, 0, 0), ex(1, 1, 7, 4, 1, 2, 2, 1));
      run(ins(0, 1, 7, 7, 0, 12, 0, 1, 0, 'h5, 0, 0, 0, 0), ex(1, 1, 7, 4, 1, 2, 3, 1));
      run(ins(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 1, 0, 0, 0, 0, 0, 1));
      run(ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 'hCC, 1), ex(0, 0, 0, 0, 0, 0, 0, 1));
      run(idle(1), ex(0, 0, 0, 0, 0, 0, 0, 1));
      run(idle(1), ex(0, 0, 0, 0, 0, 0, 0, 1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_reservation_station.md
# alu_reservation_station

Consumer-side counterpart of the common data bus: holds ALU instructions whose operands may still be pending, snoops CDB broadcasts (tag/data) to capture those operands, and forwards ready instructions to the ALU through a valid/ready handshake. It sits between the dispatch stage and the ALU. The ALU's result returns on the CDB and wakes up dependent entries in this block.

## Interface
- ENTRIES, 4: number of station slots (power of two, ≥2)
- TAG_W, `tagWidth`: rename tag width
- DATA_W, `dataWidth`: operand/result width
- OP_W, 4: ALU opcode width
- clk  input  1  rising-edge clock (single clock domain)
- rst  input  1  synchronous, active-high reset
- issueValid  input  1  dispatch presents an instruction
- issueReady  output  1  station can accept one instruction this cycle
- issueOp  input  OP_W  opcode
- issueDestTag  input  TAG_W  tag the ALU result will carry on the CDB
- issueSrc1Rdy / issueSrc2Rdy  input  1 each  operand value already known
- issueSrc1Tag / issueSrc2Tag  input  TAG_W each  producer tag when not ready
- issueSrc1Data / issueSrc2Data  input  DATA_W each  operand value when ready
- cdbValid  input  1  CDB broadcast valid (driven by the bus finish signal)
- cdbTag  input  TAG_W  broadcast tag
- cdbData  input  DATA_W  broadcast value
- exValid  output  1  instruction presented to ALU
- exReady  input  1  ALU accepts this cycle
- exOp  output  OP_W  opcode to ALU
- exDestTag  output  TAG_W  destination tag to ALU
- exSrc1 / exSrc2  output  DATA_W each  operand values
- occupancy  output  clog2(ENTRIES)+1  number of valid entries

## Operation
- Each entry: valid, op, destTag, and per operand {rdy, tag, data}.
- Allocation: on issueValid && issueReady, write into the lowest-index entry free at the start of the cycle; an entry freed in the same cycle is not reused until the next cycle.
- issueReady = (occupancy < ENTRIES); purely from registered state, independent of issueValid and exReady.
- Dispatch bypass: an incoming operand with Rdy=0 whose Tag equals cdbTag while cdbValid is high is stored as rdy=1 with data=cdbData.
- Wakeup: every valid entry with operand rdy=0 and tag == cdbTag under cdbValid sets rdy=1 and latches cdbData. Both operands of one entry may wake on the same broadcast. Non-matching broadcasts change nothing.
- Select: combinationally choose the lowest-index valid entry with both rdy bits set, using registered state only; entries woken this cycle become eligible next cycle.
- Output register: when !exValid || exReady, load the selected entry into the ex* registers, set exValid=1, and clear that entry's valid bit. If no entry is eligible, exValid goes to 0. Otherwise the ex* registers hold.
- occupancy next = occupancy + alloc − free (net 0 when both happen).
- Reset: all entry valid bits 0, exValid 0, exOp/exDestTag/exSrc1/exSrc2 0, occupancy 0, so issueReady is 1 in the first cycle after reset. Reset mid-operation discards all entries and any in-flight ex output, with no handshake completion.

## Timing
- Allocation edge E0 with both operands ready: exValid=1 after E1 (one-cycle latency) when the output register is free.
- Operand woken by CDB at edge E0: the entry is eligible in cycle E0→E1, so exValid rises after E1.
- exValid and payload stay stable until exValid && exReady is sampled. Back-to-back transfers occur every cycle while exReady=1 and eligible entries exist.
- The station accepts a new instruction in the same cycle it forwards one to the ALU, keeping throughput at one per cycle.
- The block has no combinational path from exReady to issueReady or from issueValid to exValid.

## Test plan
- Reset, then dispatch op=3, dest=5, src1=10 (rdy), src2=20 (rdy), exReady=1 → exValid=1 one cycle after accept with exSrc1=10, exSrc2=20, exDestTag=5, and occupancy back to 0.
- Dispatch with src1 pending on tag 7; two cycles later CDB {7, 0xAB} → exValid rises the cycle after the broadcast with exSrc1=0xAB. No exValid before that.
- Dispatch with src1 pending on tag 2 while the CDB broadcasts tag 2 / 0x55 in the same cycle → the entry stores 0x55 and reaches the ALU one cycle after accept.
- Fill 4 entries all pending on tag 9 with exReady=0 → issueReady=0 and occupancy=4. Broadcast tag 9, then raise exReady → entries drain in index order 0..3 on 4 consecutive cycles, and issueReady returns to 1 after the first drain.
- Hold exReady=0 with exValid=1 for 3 cycles → payload stays constant. In the same cycle as the next accept, dispatch a new instruction → occupancy is unchanged (net 0).
- Assert rst while 3 entries are valid and exValid=1 → the next cycle shows exValid=0, occupancy=0, issueReady=1, and a later CDB broadcast produces no exValid.
